// File: rtl/cpu_defs.sv
// Shared definitions for the MIPS front end.
//   PC_STEP          : byte distance between consecutive instruction words
//   DEFAULT_RESET_PC : first fetch address after clr unless overridden
//   fetch_state_t    : fetch engine states
//   instruction field positions and small field-extraction helpers
package cpu_defs;

  localparam int          PC_STEP          = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // ISSUE: free to launch a request; WAIT: request outstanding, data wanted;
  // DROP: request outstanding but a redirect made its data stale.
  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;

  function automatic logic [5:0] instr_op(input logic [31:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [4:0] instr_rs(input logic [31:0] instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [4:0] instr_rt(input logic [31:0] instr);
    return instr[RT_MSB:RT_LSB];
  endfunction

  function automatic logic [4:0] instr_rd(input logic [31:0] instr);
    return instr[RD_MSB:RD_LSB];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries.
// The head entry is kept in its own register so the outputs are pure flops
// and hold their last value when the FIFO drains.
//   clk, clr    : clock, synchronous active-high reset
//   push        : write push_data (caller guarantees a free slot)
//   pop         : consume the head entry (ignored when empty)
//   flush       : discard all entries; head_data keeps its last value
//   count       : number of stored entries
//   head_valid  : head_data holds a stored entry
//   head_data   : oldest stored entry
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           push_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       head_valid,
  output logic [WIDTH-1:0]           head_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             head_valid_reg, head_valid_next;
  logic [WIDTH-1:0] head_data_reg, head_data_next;
  logic [DEPTH-1:0] slot_wr;
  logic             do_push, do_pop;

  assign do_push    = push && !flush && (count_reg != CNT_W'(DEPTH));
  assign do_pop     = pop && head_valid_reg;
  assign rd_ptr_inc = rd_ptr_reg + PTR_W'(1);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    assign slot_wr[gi] = do_push && (wr_ptr_reg == PTR_W'(gi));
  end

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Next head: after a pop the following entry is either already in the
  // array or is the word being pushed this very cycle (when only one was held).
  always_comb begin
    head_valid_next = head_valid_reg;
    head_data_next  = head_data_reg;
    if (do_pop) begin
      if (count_reg > CNT_W'(1)) begin
        head_valid_next = 1'b1;
        head_data_next  = mem_reg[rd_ptr_inc];
      end else if (do_push) begin
        head_valid_next = 1'b1;
        head_data_next  = push_data;
      end else begin
        head_valid_next = 1'b0;
      end
    end else if (do_push && (count_reg == '0)) begin
      head_valid_next = 1'b1;
      head_data_next  = push_data;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_wr[i]) begin
        mem_reg[i] <= push_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      head_valid_reg <= 1'b0;
      head_data_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      head_valid_reg <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_inc;
      end
      count_reg      <= count_next;
      head_valid_reg <= head_valid_next;
      head_data_reg  <= head_data_next;
    end
  end

  assign count      = count_reg;
  assign head_valid = head_valid_reg;
  assign head_data  = head_data_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch engine: owns the PC, issues one word request at a time
// to instruction memory (req/ack), buffers returned words with their PC and
// hands them to decode over valid/ready. Redirects flush everything in flight.
//   clk, clr          : clock, synchronous active-high reset
//   imem_req/addr     : request to instruction memory (word aligned)
//   imem_ack/rdata    : memory return, one cycle wide
//   redirect/_pc      : taken branch/jump from execute
//   out_valid/ready   : handshake to decode
//   out_instr/out_pc  : head instruction and its address
module fetch_unit
  import cpu_defs::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEFAULT_RESET_PC),
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              clr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc
);

  localparam int ENTRY_W = ADDR_W + 32;
  localparam int CNT_W   = $clog2(FIFO_DEPTH+1);

  fetch_state_t      state_reg;
  logic [ADDR_W-1:0] fetch_pc_reg;
  logic              imem_req_reg;
  logic [ADDR_W-1:0] imem_addr_reg;

  logic [ADDR_W-1:0] redirect_tgt;
  logic [ADDR_W-1:0] pc_plus4;
  logic              ack_ok;
  logic              pop;
  logic              fifo_push;
  logic              room_issue;
  logic              room_chain;
  logic [CNT_W-1:0]  fifo_count;
  logic              head_valid;
  logic [ENTRY_W-1:0] head_data;
  logic              unused_low_bits;

  assign redirect_tgt    = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_low_bits = ^redirect_pc[1:0];
  assign pc_plus4        = fetch_pc_reg + ADDR_W'(PC_STEP);
  assign ack_ok          = imem_ack && imem_req_reg;
  assign pop             = head_valid && out_ready;
  assign fifo_push       = (state_reg == WAIT) && ack_ok && !redirect;

  // A slot freed by a pop on this edge is usable right away.
  assign room_issue = (fifo_count < CNT_W'(FIFO_DEPTH)) || pop;
  // At an ack edge the returning word occupies one slot; the next request
  // may only reserve another if one is still free after the push.
  assign room_chain = (fifo_count < CNT_W'(FIFO_DEPTH-1)) || pop;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .clr        (clr),
    .push       (fifo_push),
    .pop        (pop),
    .flush      (redirect),
    .push_data  ({fetch_pc_reg, imem_rdata}),
    .count      (fifo_count),
    .head_valid (head_valid),
    .head_data  (head_data)
  );

  // The ack edge of a useful request also makes the ISSUE decision, so the
  // next request is visible the cycle after the ack (back-to-back fetch).
  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg     <= ISSUE;
      fetch_pc_reg  <= RESET_PC;
      imem_req_reg  <= 1'b0;
      imem_addr_reg <= RESET_PC;
    end else if (redirect) begin
      fetch_pc_reg <= redirect_tgt;
      case (state_reg)
        ISSUE: begin
          if (room_issue) begin
            // Launch still targets the old PC; its data will be thrown away.
            imem_req_reg  <= 1'b1;
            imem_addr_reg <= fetch_pc_reg;
            state_reg     <= DROP;
          end else begin
            imem_addr_reg <= redirect_tgt;
          end
        end
        WAIT, DROP: begin
          if (ack_ok) begin
            imem_req_reg  <= 1'b0;
            imem_addr_reg <= redirect_tgt;
            state_reg     <= ISSUE;
          end else begin
            state_reg <= DROP;
          end
        end
        default: state_reg <= ISSUE;
      endcase
    end else begin
      case (state_reg)
        ISSUE: begin
          imem_addr_reg <= fetch_pc_reg;
          if (room_issue) begin
            imem_req_reg <= 1'b1;
            state_reg    <= WAIT;
          end else begin
            imem_req_reg <= 1'b0;
          end
        end
        WAIT: begin
          if (ack_ok) begin
            fetch_pc_reg  <= pc_plus4;
            imem_addr_reg <= pc_plus4;
            if (room_chain) begin
              imem_req_reg <= 1'b1;
            end else begin
              imem_req_reg <= 1'b0;
              state_reg    <= ISSUE;
            end
          end
        end
        DROP: begin
          if (ack_ok) begin
            imem_req_reg  <= 1'b0;
            imem_addr_reg <= fetch_pc_reg;
            state_reg     <= ISSUE;
          end
        end
        default: state_reg <= ISSUE;
      endcase
    end
  end

  assign imem_req  = imem_req_reg;
  assign imem_addr = imem_addr_reg;
  assign out_valid = head_valid;
  assign out_instr = head_data[31:0];
  assign out_pc    = head_data[ENTRY_W-1:32];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable instruction memory
// model drives the main instance; a second instance starting near the top of
// the address space checks PC wrap-around.
module tb_fetch_unit;
  import cpu_defs::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  // wrap-around instance
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic        w_redirect = 1'b0;
  logic [31:0] w_redirect_pc = '0;
  logic        w_valid;
  logic        w_ready = 1'b1;
  logic [31:0] w_instr;
  logic [31:0] w_pc;

  int n_checks = 0;
  int n_errors = 0;
  int ack_lat  = 1;

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .clr(clr),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
    .clk(clk), .clr(clr),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata),
    .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .out_valid(w_valid), .out_ready(w_ready),
    .out_instr(w_instr), .out_pc(w_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2008_0005;
      32'h0000_0004: return 32'h2009_0007;
      default:       return a ^ 32'h3C00_0000;
    endcase
  endfunction

  // Memory: a request starts in a cycle with req=1 that is not an ack cycle;
  // ack arrives ack_lat cycles after that first cycle.
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr_lat;
  always @(posedge clk) begin
    if (clr) begin
      imem_ack   <= 1'b0;
      imem_rdata <= '0;
      mem_busy   <= 1'b0;
      mem_cnt    <= 0;
    end else if (imem_ack) begin
      imem_ack <= 1'b0;
    end else if (mem_busy) begin
      if (mem_cnt <= 1) begin
        imem_ack   <= 1'b1;
        imem_rdata <= mem_word(mem_addr_lat);
        mem_busy   <= 1'b0;
      end else begin
        mem_cnt <= mem_cnt - 1;
      end
    end else if (imem_req) begin
      if (ack_lat <= 1) begin
        imem_ack   <= 1'b1;
        imem_rdata <= mem_word(imem_addr);
      end else begin
        mem_busy     <= 1'b1;
        mem_cnt      <= ack_lat - 1;
        mem_addr_lat <= imem_addr;
      end
    end
  end

  // Wrap instance memory: fixed 1-cycle latency, word = ~address.
  always @(posedge clk) begin
    if (clr) begin
      w_ack   <= 1'b0;
      w_rdata <= '0;
    end else begin
      w_ack   <= w_req && !w_ack;
      w_rdata <= ~w_addr;
    end
  end

  logic [31:0] w_pc_q[$];
  logic [31:0] w_instr_q[$];
  always @(negedge clk) begin
    if (clr) begin
      w_pc_q.delete();
      w_instr_q.delete();
    end else if (w_valid && w_pc_q.size() < 3) begin
      w_pc_q.push_back(w_pc);
      w_instr_q.push_back(w_instr);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    repeat (3) step();
    clr = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int i;
    i = 0;
    while (!out_valid && i < 20) begin
      step();
      i++;
    end
    check({tag, "_timeout"}, 64'(out_valid), 64'd1);
  endtask

  initial begin
    int k;

    // ---- Test 1: reset state and basic 2-cycle cadence
    out_ready = 1'b1;
    ack_lat   = 1;
    do_reset();
    $display("t1 reset state");
    check("rst_req",   64'(imem_req),  64'd0);
    check("rst_addr",  64'(imem_addr), 64'h0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_instr", 64'(out_instr), 64'h0);
    check("rst_pc",    64'(out_pc),    64'h0);
    step();
    $display("t1 first request");
    check("t1_req0",  64'(imem_req),  64'd1);
    check("t1_addr0", 64'(imem_addr), 64'h0);
    step();
    check("t1_valid_ack_cycle", 64'(out_valid), 64'd0);
    step();
    $display("t1 first instruction");
    check("t1_valid0", 64'(out_valid), 64'd1);
    check("t1_pc0",    64'(out_pc),    64'h0);
    check("t1_instr0", 64'(out_instr), 64'h2008_0005);
    check("t1_op0",    64'(instr_op(out_instr)), 64'h08);
    check("t1_req4",   64'(imem_req),  64'd1);
    check("t1_addr4",  64'(imem_addr), 64'h4);
    step();
    check("t1_gap", 64'(out_valid), 64'd0);
    step();
    $display("t1 second instruction");
    check("t1_valid1", 64'(out_valid), 64'd1);
    check("t1_pc1",    64'(out_pc),    64'h4);
    check("t1_instr1", 64'(out_instr), 64'h2009_0007);
    check("t1_addr8",  64'(imem_addr), 64'h8);

    // ---- Test 2: backpressure fills exactly two entries
    out_ready = 1'b0;
    do_reset();
    repeat (10) step();
    $display("t2 stalled fifo");
    check("t2_valid", 64'(out_valid), 64'd1);
    check("t2_pc0",   64'(out_pc),    64'h0);
    check("t2_instr", 64'(out_instr), 64'h2008_0005);
    check("t2_noreq", 64'(imem_req),  64'd0);

    // wrap instance has delivered its first three words by now
    $display("t5 wrap sequence");
    check("t5_count", 64'(w_pc_q.size()), 64'd3);
    if (w_pc_q.size() == 3) begin
      check("t5_pc0",    64'(w_pc_q[0]),    64'hFFFF_FFF8);
      check("t5_pc1",    64'(w_pc_q[1]),    64'hFFFF_FFFC);
      check("t5_pc2",    64'(w_pc_q[2]),    64'h0000_0000);
      check("t5_instr2", 64'(w_instr_q[2]), 64'hFFFF_FFFF);
    end

    out_ready = 1'b1;
    ack_lat   = 3;
    step();
    $display("t2 drain and resume");
    check("t2_valid_pc4", 64'(out_valid), 64'd1);
    check("t2_pc4",       64'(out_pc),    64'h4);
    check("t2_resume",    64'(imem_req),  64'd1);
    check("t2_addr8",     64'(imem_addr), 64'h8);

    // ---- Test 3: redirect during WAIT with slow ack
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0040;
    step();
    redirect = 1'b0;
    $display("t3 redirect in wait");
    check("t3_flush",    64'(out_valid), 64'd0);
    check("t3_hold_req", 64'(imem_req),  64'd1);
    check("t3_hold_a",   64'(imem_addr), 64'h8);
    step();
    check("t3_hold_b",   64'(imem_addr), 64'h8);
    step();
    check("t3_ack_req",  64'(imem_req),  64'd1);
    check("t3_ack_addr", 64'(imem_addr), 64'h8);
    step();
    check("t3_drop_req",  64'(imem_req),  64'd0);
    check("t3_drop_addr", 64'(imem_addr), 64'h40);
    check("t3_drop_val",  64'(out_valid), 64'd0);
    ack_lat = 1;
    step();
    check("t3_req40", 64'(imem_req),  64'd1);
    check("t3_addr40", 64'(imem_addr), 64'h40);
    wait_valid("t3_w40");
    check("t3_pc40",    64'(out_pc),    64'h40);
    check("t3_instr40", 64'(out_instr), 64'h3C00_0040);
    step();
    wait_valid("t3_w44");
    check("t3_pc44", 64'(out_pc), 64'h44);
    out_ready = 1'b0;

    // ---- Test 4: redirect with same-cycle ack and head consumption
    k = 0;
    while (!(imem_ack && out_valid) && k < 20) begin
      step();
      k++;
    end
    $display("t4 redirect with ack and pop");
    check("t4_setup",   64'(imem_ack && out_valid), 64'd1);
    check("t4_head_pc", 64'(out_pc), 64'h44);
    out_ready   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    check("t4_empty",  64'(out_valid), 64'd0);
    check("t4_noreq",  64'(imem_req),  64'd0);
    check("t4_addr",   64'(imem_addr), 64'h100);
    step();
    check("t4_req100",  64'(imem_req),  64'd1);
    check("t4_addr100", 64'(imem_addr), 64'h100);
    wait_valid("t4_w100");
    check("t4_pc100", 64'(out_pc), 64'h100);

    // ---- Test 6: clr in WAIT with ack pending and a buffered entry
    out_ready = 1'b0;
    ack_lat   = 3;
    step();
    $display("t6 clr mid-transaction");
    check("t6_pre_valid", 64'(out_valid), 64'd1);
    check("t6_pre_req",   64'(imem_req),  64'd1);
    check("t6_pre_addr",  64'(imem_addr), 64'h104);
    clr = 1'b1;
    step();
    clr       = 1'b0;
    ack_lat   = 1;
    out_ready = 1'b1;
    check("t6_valid", 64'(out_valid), 64'd0);
    check("t6_req",   64'(imem_req),  64'd0);
    check("t6_addr",  64'(imem_addr), 64'h0);
    step();
    check("t6_req0",  64'(imem_req),  64'd1);
    check("t6_addr0", 64'(imem_addr), 64'h0);
    wait_valid("t6_w0");
    check("t6_pc0",    64'(out_pc),    64'h0);
    check("t6_instr0", 64'(out_instr), 64'h2008_0005);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of decode/control in the MIPS datapath. It replaces the free-running PC with a fetch engine that:
- owns the program counter;
- issues word requests to instruction memory over a req/ack handshake;
- buffers returned instructions with their PC in a small FIFO;
- presents them to decode over a valid/ready handshake.
Branch/jump redirects from execute flush in-flight and buffered instructions.

Parameters:
ADDR_W, 32, width of PC and memory address.
RESET_PC, 32'h0000_0000, first fetch address after clr.
FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2).

Ports:
clk  in  1  system clock, all state updates on rising edge
clr  in  1  synchronous active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  ADDR_W  word address of request, low 2 bits always 0
imem_ack  in  1  memory returns imem_rdata this cycle
imem_rdata  in  32  instruction word, valid when imem_ack=1
redirect  in  1  taken branch/jump; flush and refetch
redirect_pc  in  ADDR_W  new fetch address when redirect=1
out_valid  out  1  out_instr/out_pc hold a valid instruction
out_ready  in  1  decode accepts entry when out_valid & out_ready
out_instr  out  32  instruction to decode (op = [31:26] etc.)
out_pc  out  ADDR_W  address of out_instr

Behaviour:
- Reset (clr=1 at an edge): state=ISSUE, fetch_pc=RESET_PC, FIFO emptied, imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0. The memory model shares clr; any ack in the cycle clr is high is ignored. A reset mid-transaction abandons the request.
- FSM states:
  - ISSUE: if fifo_count < FIFO_DEPTH, assert imem_req with imem_addr=fetch_pc and go to WAIT. Otherwise imem_req=0 and stay.
  - WAIT: imem_req held 1 and imem_addr held stable until imem_ack. On ack:
    - push {fetch_pc, imem_rdata};
    - fetch_pc += 4;
    - go to ISSUE.
  - DROP: entered when a redirect arrives in WAIT without same-cycle ack. imem_req stays 1 with the old address. On ack, data is discarded and the FSM goes to ISSUE.
- Only one request is outstanding at a time. The FIFO slot is reserved at issue, so a push never finds the FIFO full.
- Ack is only legal while imem_req=1. Minimum ack latency is the cycle after req first asserts.
- Latency:
  - An ack in cycle N makes out_valid=1 in cycle N+1.
  - A new request can assert in cycle N+1 (back-to-back).
  - Steady-state throughput is one instruction per 2 cycles with 1-cycle memory.
- FIFO:
  - out_* show the head entry; they are registered, with no combinational path from imem_rdata.
  - A pop and a push in the same cycle are both honoured, and the count is unchanged.
  - out_instr/out_pc keep their last value when empty; out_valid=0 then.
- Redirect (priority over everything except clr):
  - fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00} (misaligned low bits forced to 0).
  - The FIFO is flushed, so out_valid=0 next cycle. If out_valid & out_ready in the same cycle, that head entry counts as consumed, and the rest is flushed.
  - Redirect in ISSUE: no request is outstanding. A request launched that cycle goes to the old address, so the FSM goes to DROP. If no request was launched, the FSM stays in ISSUE with the new PC.
  - Redirect in WAIT with same-cycle ack: data discarded, next state ISSUE.
  - Redirect in WAIT without ack: next state DROP.
  - Redirect in DROP: target updated again, FSM stays in DROP.
- PC arithmetic is modulo 2^ADDR_W: 32'hFFFF_FFFC + 4 = 0.
- out_valid may drop only through redirect or clr. Once asserted, out_instr is stable until accepted.

Decomposition:
- Shared package cpu_defs:
  - PC_STEP=4;
  - RESET_PC default;
  - fetch FSM state encoding {ISSUE, WAIT, DROP};
  - instruction field positions (op[31:26], rs[25:21], rt[20:16], rd[15:11]).
- Sub-module fetch_fifo: parameterised depth/width synchronous FIFO with push, pop, flush, count, head outputs, and synchronous clr. fetch_unit instantiates it with width 32+ADDR_W.

Test Plan:
- clr 3 cycles, 1-cycle ack memory holding 0x20080005 @0, 0x20090007 @4, out_ready=1 → first imem_req at addr 0 one cycle after clr drops; out_pc 0 then 4; out_instr matches memory; no gaps beyond 2-cycle cadence.
- out_ready=0 for 10 cycles → exactly 2 entries buffered (pc 0,4), imem_req=0 afterwards; on out_ready=1, entries pop in order, and fetch of pc 8 resumes the cycle after the first pop.
- Redirect to 0x40 while WAIT at pc 8 with ack delayed 3 cycles → req held at addr 8 until ack, data dropped, next req addr 0x40; out_pc sequence continues 0x40, 0x44.
- Redirect to 0x103 with same-cycle ack and out_valid&out_ready → head consumed, ack data discarded, FIFO empty next cycle, next imem_addr=0x100.
- Start with RESET_PC=32'hFFFF_FFF8 → out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- clr asserted while WAIT with ack pending → out_valid=0, imem_req=0 next cycle, restart at RESET_PC with no stale entry delivered.
